// File: rtl/tt_slice_arbiter.sv
// Round-robin, time-sliced arbiter sharing one 8-bit output bus among 4 lanes.
// Each grant is bounded by a slice counter and followed by a one-cycle dead gap.
module tt_slice_arbiter #(
    parameter int                CNT_W        = 24,
    parameter logic [CNT_W-1:0]  SLICE_CYCLES = 24'd10_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ena,
    input  logic [3:0]  i_req,
    input  logic [3:0]  i_done,
    input  logic [31:0] i_lane_data,
    output logic [3:0]  o_gnt,
    output logic [7:0]  o_bus_out,
    output logic        o_busy,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = SLICE_CYCLES - 1'b1;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_gnt, w_gnt_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [1:0]       r_owner, w_owner_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic [1:0]       w_sel;
    logic [1:0]       w_idx;
    logic             w_found;
    logic             w_rel;
    logic             w_exp;

    // First requesting lane at or after ptr, wrapping modulo 4
    always_comb begin
        w_sel   = 2'd0;
        w_idx   = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_rel = i_done[r_owner] | ~i_req[r_owner];
    assign w_exp = (r_cnt == LP_LAST) & ~w_rel;

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_cnt_nxt     = r_cnt;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_timeout_nxt = r_timeout;
        if (i_ena) begin
            unique case (r_state)
                IDLE: begin
                    w_timeout_nxt = 1'b0;
                    if (w_found) begin
                        w_state_nxt = GRANT;
                        w_gnt_nxt   = 4'b0001 << w_sel;
                        w_owner_nxt = w_sel;
                        w_cnt_nxt   = '0;
                    end
                end
                GRANT: begin
                    if (w_rel || w_exp) begin
                        w_state_nxt   = GAP;
                        w_gnt_nxt     = 4'b0000;
                        w_ptr_nxt     = r_owner + 2'd1;
                        w_timeout_nxt = w_exp;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    w_state_nxt   = IDLE;
                    w_timeout_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_gnt_nxt     = 4'b0000;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= 4'b0000;
            r_cnt     <= '0;
            r_ptr     <= 2'd0;
            r_owner   <= 2'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Bus is a plain AND-OR mux on the registered one-hot grant
    always_comb begin
        o_bus_out = 8'h00;
        for (int i = 0; i < 4; i++) begin
            o_bus_out = o_bus_out | ({8{r_gnt[i]}} & i_lane_data[8*i +: 8]);
        end
    end

    assign o_gnt     = r_gnt;
    assign o_busy    = (r_state == GRANT);
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_tt_slice_arbiter.sv
// Directed bench for tt_slice_arbiter: SLICE_CYCLES=4 main instance and a
// SLICE_CYCLES=1 instance for the single-cycle slice boundary.
module tb_tt_slice_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena   = 1'b1;
    logic [3:0]  req   = 4'b0000;
    logic [3:0]  done  = 4'b0000;
    logic [3:0]  req1  = 4'b0000;
    logic [3:0]  done1 = 4'b0000;
    logic [31:0] data  = {8'h3C, 8'hA5, 8'h5A, 8'h11};

    logic [3:0]  gnt, gnt1;
    logic [7:0]  bus, bus1;
    logic        busy, busy1;
    logic        tmo, tmo1;

    int vectors     = 0;
    int miscompares = 0;
    int lanes[5]    = '{0, 1, 2, 3, 0};

    tt_slice_arbiter #(.CNT_W(24), .SLICE_CYCLES(24'd4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ena       (ena),
        .i_req       (req),
        .i_done      (done),
        .i_lane_data (data),
        .o_gnt       (gnt),
        .o_bus_out   (bus),
        .o_busy      (busy),
        .o_timeout   (tmo)
    );

    tt_slice_arbiter #(.CNT_W(24), .SLICE_CYCLES(24'd1)) dut1 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ena       (ena),
        .i_req       (req1),
        .i_done      (done1),
        .i_lane_data (data),
        .o_gnt       (gnt1),
        .o_bus_out   (bus1),
        .o_busy      (busy1),
        .o_timeout   (tmo1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg,
                           input logic [7:0] eb, input logic et);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".bus"}, 32'(bus), 32'(eb));
        chk({tag, ".busy"}, 32'(busy), 32'(|eg));
        chk({tag, ".tmo"}, 32'(tmo), 32'(et));
    endtask

    initial begin
        // Reset values
        #1;
        chk_out("reset", 4'b0000, 8'h00, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("idle_noreq", 4'b0000, 8'h00, 1'b0);

        // Single request: 4-cycle slice, timeout, regrant after 2 idle cycles
        req = 4'b0100;
        tick();
        chk_out("t1_g1", 4'b0100, 8'hA5, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk_out($sformatf("t1_g%0d", i), 4'b0100, 8'hA5, 1'b0);
        end
        tick();
        chk_out("t1_expire", 4'b0000, 8'h00, 1'b1);
        tick();
        chk_out("t1_idle", 4'b0000, 8'h00, 1'b0);
        tick();
        chk_out("t1_regrant", 4'b0100, 8'hA5, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("t1_release", 4'b0000, 8'h00, 1'b0);
        tick();

        // Round robin from ptr=0 after a fresh reset
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        rst_n = 1'b1;
        tick();
        for (int n = 0; n < 5; n++) begin
            chk_out($sformatf("rr%0d_grant", n), 4'(1 << lanes[n]),
                    data[8*lanes[n] +: 8], 1'b0);
            done = 4'(1 << lanes[n]);
            tick();
            chk_out($sformatf("rr%0d_gap", n), 4'b0000, 8'h00, 1'b0);
            done = 4'b0000;
            tick();
            chk_out($sformatf("rr%0d_idle", n), 4'b0000, 8'h00, 1'b0);
            tick();
        end

        // Done beats expiry on lane1's 4th grant cycle
        req = 4'b0011;
        chk_out("t3_g1", 4'b0010, 8'h5A, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk_out($sformatf("t3_g%0d", i), 4'b0010, 8'h5A, 1'b0);
        end
        done = 4'b0010;
        tick();
        chk_out("t3_done_beats", 4'b0000, 8'h00, 1'b0);
        done = 4'b0000;
        tick();
        chk_out("t3_idle", 4'b0000, 8'h00, 1'b0);
        tick();
        chk_out("t3_next_lane0", 4'b0001, 8'h11, 1'b0);

        // Request withdrawal on lane3
        req = 4'b1000;
        tick();
        chk_out("t4_lane0_rel", 4'b0000, 8'h00, 1'b0);
        tick();
        tick();
        chk_out("t4_g1", 4'b1000, 8'h3C, 1'b0);
        tick();
        chk_out("t4_g2", 4'b1000, 8'h3C, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("t4_gap", 4'b0000, 8'h00, 1'b0);
        tick();

        // ena freeze at cnt=1; bus still tracks lane data
        req = 4'b0010;
        tick();
        chk_out("t5_g1", 4'b0010, 8'h5A, 1'b0);
        tick();
        chk_out("t5_g2", 4'b0010, 8'h5A, 1'b0);
        ena = 1'b0;
        data[15:8] = 8'h77;
        #1;
        chk_out("t5_bus_follow", 4'b0010, 8'h77, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("t5_frz%0d", i), 4'b0010, 8'h77, 1'b0);
        end
        ena = 1'b1;
        data[15:8] = 8'h5A;
        tick();
        chk_out("t5_g3", 4'b0010, 8'h5A, 1'b0);
        tick();
        chk_out("t5_g4", 4'b0010, 8'h5A, 1'b0);
        tick();
        chk_out("t5_timeout", 4'b0000, 8'h00, 1'b1);
        ena = 1'b0;
        req = 4'b0000;
        tick();
        chk_out("t5_tmo_hold", 4'b0000, 8'h00, 1'b1);
        ena = 1'b1;
        tick();
        chk_out("t5_tmo_clr", 4'b0000, 8'h00, 1'b0);

        // Async reset mid-grant, then search restarts at ptr=0
        req = 4'b0100;
        tick();
        chk_out("t6_g1", 4'b0100, 8'hA5, 1'b0);
        tick();
        chk_out("t6_g2", 4'b0100, 8'hA5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t6_async", 4'b0000, 8'h00, 1'b0);
        req = 4'b1100;
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("t6_ptr0", 4'b0100, 8'hA5, 1'b0);

        // SLICE_CYCLES=1: exactly one grant cycle then timeout
        req  = 4'b0000;
        req1 = 4'b0001;
        tick();
        chk("s1_gnt", 32'(gnt1), 32'h1);
        chk("s1_bus", 32'(bus1), 32'h11);
        chk("s1_tmo0", 32'(tmo1), 32'h0);
        tick();
        chk("s1_gap_gnt", 32'(gnt1), 32'h0);
        chk("s1_gap_tmo", 32'(tmo1), 32'h1);
        chk("s1_gap_busy", 32'(busy1), 32'h0);
        tick();
        chk("s1_idle_tmo", 32'(tmo1), 32'h0);
        tick();
        chk("s1_regrant", 32'(gnt1), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
